// File: rtl/game_ctrl.sv
// Four-in-a-row game controller: drops pieces into a 7x6 board, scans
// the chosen column one row per cycle, then checks the mover for a win
// or a full-board draw.
module game_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  col_sel,
  input  logic        drop,
  input  logic        restart,
  output logic [41:0] red_enc,
  output logic [41:0] yel_enc,
  output logic        turn,
  output logic        busy,
  output logic        illegal,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int unsigned COLS  = 7;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned CELLS = COLS * ROWS;
  localparam int unsigned IDXW  = 6;

  localparam logic [2:0]      BOTTOM_ROW = 3'd5;
  localparam logic [2:0]      BAD_COL    = 3'd7;
  localparam logic [IDXW-1:0] LAST_MOVE  = 6'd42;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_RED  = 2'b01;
  localparam logic [1:0] WIN_YEL  = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    CHECK = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CELLS-1:0]  red_q, red_d;
  logic [CELLS-1:0]  yel_q, yel_d;
  logic [2:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  logic [IDXW-1:0]   moves_q, moves_d;
  logic              turn_q, turn_d;
  logic              busy_q, busy_d;
  logic              illegal_q, illegal_d;
  logic              over_q, over_d;
  logic [1:0]        winner_q, winner_d;

  logic [IDXW-1:0]   cell_idx_c;
  logic [CELLS-1:0]  occ_c;
  logic [CELLS-1:0]  mover_c;
  logic              win_c;

  // Any horizontal, vertical or diagonal run of four set bits on a board.
  function automatic logic four_in_row(input logic [CELLS-1:0] b);
    logic            hit;
    logic [IDXW-1:0] i;
    hit = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        i = IDXW'(r * COLS + c);
        if (c <= COLS - 4)
          hit |= b[i] & b[i + 6'd1] & b[i + 6'd2] & b[i + 6'd3];
        if (r <= ROWS - 4)
          hit |= b[i] & b[i + 6'd7] & b[i + 6'd14] & b[i + 6'd21];
        if ((r <= ROWS - 4) && (c <= COLS - 4))
          hit |= b[i] & b[i + 6'd8] & b[i + 6'd16] & b[i + 6'd24];
        if ((r <= ROWS - 4) && (c >= 3))
          hit |= b[i] & b[i + 6'd6] & b[i + 6'd12] & b[i + 6'd18];
      end
    end
    return hit;
  endfunction

  // Cell under the scan pointer, combined occupancy and the mover's board.
  always_comb begin
    cell_idx_c = IDXW'(row_q) * 6'd7 + IDXW'(col_q);
    occ_c      = red_q | yel_q;
    mover_c    = turn_q ? yel_q : red_q;
    win_c      = four_in_row(mover_c);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    red_d     = red_q;
    yel_d     = yel_q;
    row_d     = row_q;
    col_d     = col_q;
    moves_d   = moves_q;
    turn_d    = turn_q;
    illegal_d = 1'b0;
    over_d    = over_q;
    winner_d  = winner_q;

    if (restart) begin
      state_d  = IDLE;
      red_d    = '0;
      yel_d    = '0;
      row_d    = BOTTOM_ROW;
      moves_d  = '0;
      turn_d   = 1'b0;
      over_d   = 1'b0;
      winner_d = WIN_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (drop) begin
            if (col_sel != BAD_COL) begin
              col_d   = col_sel;
              row_d   = BOTTOM_ROW;
              state_d = SCAN;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        SCAN: begin
          if (!occ_c[cell_idx_c]) begin
            if (turn_q) yel_d[cell_idx_c] = 1'b1;
            else        red_d[cell_idx_c] = 1'b1;
            moves_d = moves_q + 6'd1;
            state_d = CHECK;
          end else if (row_q != 3'd0) begin
            row_d = row_q - 3'd1;
          end else begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end
        end
        CHECK: begin
          if (win_c) begin
            winner_d = turn_q ? WIN_YEL : WIN_RED;
            over_d   = 1'b1;
            state_d  = OVER;
          end else if (moves_q == LAST_MOVE) begin
            winner_d = WIN_DRAW;
            over_d   = 1'b1;
            state_d  = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == SCAN) || (state_d == CHECK);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      red_q     <= '0;
      yel_q     <= '0;
      row_q     <= BOTTOM_ROW;
      col_q     <= '0;
      moves_q   <= '0;
      turn_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
      over_q    <= 1'b0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      red_q     <= red_d;
      yel_q     <= yel_d;
      row_q     <= row_d;
      col_q     <= col_d;
      moves_q   <= moves_d;
      turn_q    <= turn_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
    end
  end

  assign red_enc   = red_q;
  assign yel_enc   = yel_q;
  assign turn      = turn_q;
  assign busy      = busy_q;
  assign illegal   = illegal_q;
  assign game_over = over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: a board-level game model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_game_ctrl;

  logic        clk;
  logic        rst;
  logic [2:0]  col_sel;
  logic        drop;
  logic        restart;
  logic [41:0] red_enc;
  logic [41:0] yel_enc;
  logic        turn;
  logic        busy;
  logic        illegal;
  logic        game_over;
  logic [1:0]  winner;

  game_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .col_sel   (col_sel),
    .drop      (drop),
    .restart   (restart),
    .red_enc   (red_enc),
    .yel_enc   (yel_enc),
    .turn      (turn),
    .busy      (busy),
    .illegal   (illegal),
    .game_over (game_over),
    .winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Game model: grid holds 0 empty, 1 red, 2 yellow; a drop's effects are
  // scheduled relative to its accept edge from the column height.
  int   grid [0:5][0:6];
  int   hgt  [0:6];
  int   m_turn, m_moves, m_busy, m_t, m_col, m_k;
  int   m_winner;
  bit   m_over, m_illegal;

  task automatic model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) grid[r][c] = 0;
    for (int c = 0; c < 7; c++) hgt[c] = 0;
    m_turn = 0; m_moves = 0; m_busy = 0; m_t = 0;
    m_winner = 0; m_over = 1'b0;
  endtask

  function automatic bit has_four(int who);
    int dr, dc, rr, cc, run;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 7; c++) begin
          run = 0;
          for (int s = 0; s < 4; s++) begin
            rr = r + s * dr;
            cc = c + s * dc;
            if (rr >= 0 && rr < 6 && cc >= 0 && cc < 7 && grid[rr][cc] == who)
              run++;
          end
          if (run == 4) return 1'b1;
        end
    end
    return 1'b0;
  endfunction

  function automatic logic [41:0] enc(int who);
    logic [41:0] e;
    e = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (grid[r][c] == who) e = e | (42'd1 << (r * 7 + c));
    return e;
  endfunction

  task automatic model_step();
    m_illegal = 1'b0;
    if (rst || restart) begin
      model_clear();
    end else if (m_busy != 0) begin
      m_t++;
      if (m_k == 6) begin
        if (m_t == 6) begin m_illegal = 1'b1; m_busy = 0; end
      end else if (m_t == m_k + 1) begin
        grid[5 - m_k][m_col] = m_turn + 1;
        hgt[m_col]++;
        m_moves++;
      end else if (m_t == m_k + 2) begin
        if (has_four(m_turn + 1)) begin
          m_winner = (m_turn == 1) ? 2 : 1;
          m_over = 1'b1;
        end else if (m_moves == 42) begin
          m_winner = 3;
          m_over = 1'b1;
        end else begin
          m_turn = 1 - m_turn;
        end
        m_busy = 0;
      end
    end else if (!m_over && drop) begin
      if (col_sel == 3'd7) m_illegal = 1'b1;
      else begin
        m_col = int'(col_sel);
        m_k = hgt[m_col];
        m_t = 0;
        m_busy = 1;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on every rising edge, from the same inputs the DUT sees.
  initial begin
    model_clear();
    m_illegal = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_red",     64'(red_enc),   64'(enc(1)));
        check("m_yel",     64'(yel_enc),   64'(enc(2)));
        check("m_turn",    64'(turn),      64'(m_turn));
        check("m_busy",    64'(busy),      64'(m_busy));
        check("m_illegal", 64'(illegal),   64'(m_illegal));
        check("m_over",    64'(game_over), 64'(m_over));
        check("m_winner",  64'(winner),    64'(m_winner));
      end
    end
  end

  task automatic do_drop(input int c);
    @(negedge clk);
    drop = 1'b1;
    col_sel = 3'(c);
    @(negedge clk);
    drop = 1'b0;
  endtask

  task automatic drop_settle(input int c);
    do_drop(c);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_red"},    64'(red_enc),   64'd0);
    check({tag, "_yel"},    64'(yel_enc),   64'd0);
    check({tag, "_turn"},   64'(turn),      64'd0);
    check({tag, "_busy"},   64'(busy),      64'd0);
    check({tag, "_ill"},    64'(illegal),   64'd0);
    check({tag, "_over"},   64'(game_over), 64'd0);
    check({tag, "_winner"}, 64'(winner),    64'd0);
  endtask

  int draw_seq [42] = '{2, 5,5,5,5,5,5, 0,0,0,0,0,0, 2,2,2,2,2,
                        3,1,1,3,3,1,1,3,3,1,1,3,
                        6,4,4,6,6,4,4,6,6,4,4,6};
  int win_seq [7] = '{0, 0, 1, 1, 2, 2, 3};

  initial begin
    rst = 1'b1; drop = 1'b0; restart = 1'b0; col_sel = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check_cleared("reset");

    // First drop lands at the bottom of column 3 in one scan cycle.
    do_drop(3);
    check("d3_busy_e0", 64'(busy), 64'd1);
    @(negedge clk);
    check("d3_red_e1", 64'(red_enc), 64'(42'd1 << 38));
    check("d3_busy_e1", 64'(busy), 64'd1);
    @(negedge clk);
    check("d3_turn_e2", 64'(turn), 64'd1);
    check("d3_busy_e2", 64'(busy), 64'd0);

    // Fill column 0, then overflow it.
    do_restart();
    for (int i = 0; i < 6; i++) drop_settle(0);
    check("col0_red", 64'(red_enc), 64'((42'd1 << 35) | (42'd1 << 21) | (42'd1 << 7)));
    check("col0_yel", 64'(yel_enc), 64'((42'd1 << 28) | (42'd1 << 14) | 42'd1));
    do_drop(0);
    repeat (5) @(negedge clk);
    check("full_ill_e5", 64'(illegal), 64'd0);
    @(negedge clk);
    check("full_ill_e6", 64'(illegal), 64'd1);
    check("full_turn", 64'(turn), 64'd0);
    check("full_red", 64'(red_enc), 64'((42'd1 << 35) | (42'd1 << 21) | (42'd1 << 7)));
    @(negedge clk);
    check("full_ill_e7", 64'(illegal), 64'd0);

    // Red wins along the bottom row; later drops are ignored.
    do_restart();
    foreach (win_seq[i]) drop_settle(win_seq[i]);
    check("win_winner", 64'(winner), 64'd1);
    check("win_over", 64'(game_over), 64'd1);
    check("win_red", 64'(red_enc), 64'(42'hF << 35));
    check("win_yel", 64'(yel_enc), 64'(42'h7 << 28));
    drop_settle(4);
    check("over_red", 64'(red_enc), 64'(42'hF << 35));
    check("over_busy", 64'(busy), 64'd0);

    // Invalid column, and a drop during busy.
    do_restart();
    do_drop(7);
    check("c7_ill", 64'(illegal), 64'd1);
    check("c7_busy", 64'(busy), 64'd0);
    do_drop(5);
    check("c5_busy", 64'(busy), 64'd1);
    do_drop(6);
    repeat (8) @(negedge clk);
    check("ign_red", 64'(red_enc), 64'(42'd1 << 40));
    check("ign_yel", 64'(yel_enc), 64'd0);
    check("ign_turn", 64'(turn), 64'd1);

    // Drop and restart together: restart wins.
    @(negedge clk);
    drop = 1'b1; col_sel = 3'd2; restart = 1'b1;
    @(negedge clk);
    drop = 1'b0; restart = 1'b0;
    check_cleared("dr_rs");
    repeat (3) @(negedge clk);
    check("dr_rs_red", 64'(red_enc), 64'd0);

    // Full board with no four-in-a-row is a draw; restart clears it.
    foreach (draw_seq[i]) drop_settle(draw_seq[i]);
    check("draw_winner", 64'(winner), 64'd3);
    check("draw_over", 64'(game_over), 64'd1);
    check("draw_full", 64'(red_enc | yel_enc), 64'({42{1'b1}}));
    do_restart();
    check_cleared("draw_rs");

    // Restart in the middle of a scan.
    for (int i = 0; i < 3; i++) drop_settle(3);
    do_drop(3);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check_cleared("mid_rs");
    repeat (6) @(negedge clk);
    check("mid_rs_ill", 64'(illegal), 64'd0);

    // Reset in the middle of a scan.
    drop_settle(1);
    do_drop(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cleared("mid_rst");
    repeat (6) @(negedge clk);
    check("mid_rst_red", 64'(red_enc), 64'd0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
